// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: word type, RAM handshake state, and the
// arbiter FSM encoding.
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  // A cache block is two words (8 bytes), so block identity is addr[31:3].
  localparam int BLK_LSB = 3;
  localparam int BLK_W   = WORD_W - BLK_LSB;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BLK_W-1:0]  blk_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DGNT = 2'd1,
    IGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM-side signals around the memory arbiter.
//
// Handshake: a requester raises REN/WEN and holds address and store data
// stable until its wait goes low. Wait low marks the single completion cycle;
// load data is meaningful only in that cycle. Dropping the request before then
// abandons the access with no completion.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  // icache side
  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  // dcache side
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  // RAM side
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramerr;

  // Arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  // Caches plus RAM model view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache and dcache. Dcache has priority,
// both words of a dcache block go out back-to-back, and a saturating
// starvation counter forces an icache grant after STARVE_LIMIT dcache grants
// taken while the icache was waiting.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                              CLK,
  input  logic                              RST,
  mem_arbiter_if.slave                      bus,
  output arb_state_t                        state_dbg,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] starve_dbg
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  arb_state_t    state, state_n;
  logic [CW-1:0] starve_cnt, starve_cnt_n;
  logic          lock_set, lock_set_n;
  logic          burst2, burst2_n;
  blk_t          lock_blk, lock_blk_n;

  logic          dreq;
  logic          starved;
  logic          blk_match;
  logic          d_live;

  logic          ram_ren;
  logic          ram_wen;
  word_t         ram_addr;
  word_t         ram_store;
  logic          i_wait;
  logic          d_wait;
  logic          ram_err;

  assign dreq      = bus.dREN | bus.dWEN;
  assign starved   = (starve_cnt == CNT_MAX) & bus.iREN;
  assign blk_match = (bus.daddr[WORD_W-1:BLK_LSB] == lock_blk);
  // After the first word of a block completes, the grant is held one more
  // cycle; only a request to the same block may use it. Anything else is not
  // presented to the RAM and the grant is released.
  assign d_live    = dreq & (~lock_set | blk_match);

  // State register and lock/starvation bookkeeping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      lock_set   <= 1'b0;
      burst2     <= 1'b0;
      lock_blk   <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_cnt_n;
      lock_set   <= lock_set_n;
      burst2     <= burst2_n;
      lock_blk   <= lock_blk_n;
    end
  end

  // Next-state decision and RAM/cache-side outputs for the current grant.
  always_comb begin
    state_n      = state;
    starve_cnt_n = starve_cnt;
    lock_set_n   = lock_set;
    burst2_n     = burst2;
    lock_blk_n   = lock_blk;
    ram_ren      = 1'b0;
    ram_wen      = 1'b0;
    ram_addr     = '0;
    ram_store    = '0;
    i_wait       = 1'b1;
    d_wait       = 1'b1;
    ram_err      = 1'b0;

    case (state)
      IDLE: begin
        lock_set_n = 1'b0;
        burst2_n   = 1'b0;
        if (!bus.iREN) begin
          starve_cnt_n = '0;
        end
        if (dreq && !starved) begin
          state_n = DGNT;
          if (bus.iREN && (starve_cnt < CNT_MAX)) begin
            starve_cnt_n = starve_cnt + CW'(1);
          end
        end else if (bus.iREN) begin
          state_n      = IGNT;
          starve_cnt_n = '0;
        end
      end

      DGNT: begin
        ram_addr  = bus.daddr;
        ram_store = bus.dstore;
        if (d_live) begin
          // A write wins when both enables are raised.
          ram_wen = bus.dWEN;
          ram_ren = bus.dREN & ~bus.dWEN;
        end
        if (!d_live) begin
          // Request dropped, or the held grant was not used by the same block.
          state_n    = IDLE;
          lock_set_n = 1'b0;
          burst2_n   = 1'b0;
        end else if (bus.ramstate == ERROR) begin
          ram_err    = 1'b1;
          state_n    = IDLE;
          lock_set_n = 1'b0;
          burst2_n   = 1'b0;
        end else if (bus.ramstate == ACCESS) begin
          d_wait = 1'b0;
          if (lock_set || burst2) begin
            // Second word of the block is done.
            state_n    = IDLE;
            lock_set_n = 1'b0;
            burst2_n   = 1'b0;
          end else begin
            // First word done: hold the grant for a possible second word.
            lock_set_n = 1'b1;
            lock_blk_n = bus.daddr[WORD_W-1:BLK_LSB];
          end
        end else if (lock_set) begin
          // Same-block follow-on accepted; it is now the second word in flight.
          lock_set_n = 1'b0;
          burst2_n   = 1'b1;
        end
      end

      IGNT: begin
        ram_addr = bus.iaddr;
        ram_ren  = bus.iREN;
        if (!bus.iREN) begin
          state_n = IDLE;
        end else if (bus.ramstate == ERROR) begin
          ram_err = 1'b1;
          state_n = IDLE;
        end else if (bus.ramstate == ACCESS) begin
          // Icache refills word by word through normal arbitration.
          i_wait  = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.ramerr   = ram_err;
  assign bus.iwait    = i_wait;
  assign bus.dwait    = d_wait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;

  assign state_dbg    = state;
  assign starve_dbg   = starve_cnt;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single RAM port between the instruction cache and the data cache of one core. It sits between the caches' memory-side request ports and the RAM model. A registered FSM grants one requester at a time, with data-cache priority. The block-burst lock keeps both words of a dcache block fill or writeback back-to-back. A starvation counter guarantees icache progress under sustained dcache traffic.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants, taken while iREN is pending, after which icache wins the next arbitration.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle iload is valid for the icache.
- iload  out  32  equals ramload (combinational).
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the cycle the dcache access completes.
- dload  out  32  equals ramload (combinational).
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  ramstate_t  FREE / BUSY / ACCESS / ERROR.
- ramerr  out  1  one-cycle pulse when ERROR is seen during a grant.

## Operation
- FSM states: IDLE, DGNT, IGNT.
- IDLE: drives no RAM request; iwait=1, dwait=1.
  - Decision rule: dreq=dREN|dWEN.
  - If dreq and not starved, go to DGNT.
  - Else if iREN, go to IGNT.
  - Else stay in IDLE.
  - starved = (starve_cnt == STARVE_LIMIT) & iREN.
- DGNT: ramaddr=daddr; ramstore=dstore; ramWEN=dWEN; ramREN=dREN&~dWEN (a write wins when both are asserted). iwait=1. dwait=~(ramstate==ACCESS).
- IGNT: ramaddr=iaddr; ramREN=iREN; ramWEN=0; ramstore=0; dwait=1; iwait=~(ramstate==ACCESS).
- Completion when ramstate==ACCESS in DGNT:
  - Latch lock_blk=daddr[31:3] and lock_set=1 on the first word of a pair.
  - Next cycle: if dreq is still high and daddr[31:3]==lock_blk and lock_set, remain in DGNT and clear lock_set (second word of the block, no bubble).
  - Otherwise go to IDLE and clear lock_set.
- Completion in IGNT: go to IDLE (icache blocks refill word by word through normal arbitration).
- Requester drops its request while granted and before ACCESS: return to IDLE next cycle with no completion.
- ramstate==ERROR while granted: pulse ramerr for one cycle, go to IDLE, keep the owner's wait high, clear lock_set.
- starve_cnt, saturating, range 0..STARVE_LIMIT:
  - +1 on each IDLE->DGNT transition taken while iREN=1.
  - Cleared on IDLE->IGNT, or on any IDLE decision with iREN=0.
  - Width is $clog2(STARVE_LIMIT+1).

## Timing
- Reset values (asynchronous, immediate): state=IDLE, starve_cnt=0, lock_set=0, lock_blk=0, iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, ramerr=0.
- RST asserted mid-access drops the RAM request in the same cycle. No completion is reported for that access.
- Arbitration latency: a request seen in IDLE reaches the RAM one cycle later, in the grant state.
- Single access: 1 IDLE cycle + RAM latency. A dcache block pair takes one extra word cycle and no IDLE bubble.
- Wait outputs are combinational from ramstate; there is no registered data path.
- iload and dload are always ramload. Validity is indicated only by the corresponding wait signal being low.

## Structure
- ramstate_t, word_t and the FSM state enum arb_state_t belong in cpu_types_pkg. Add arb_state_t there.
- Single module. The starvation counter is inline, not a flex_counter instance, because it saturates and clears conditionally.

## Test plan
- Dcache-only read, RAM latency 2 (BUSY,BUSY,ACCESS) at daddr=0x100 -> ramREN=1, ramaddr=0x100 from the cycle after the request. dwait is low only on the ACCESS cycle; dload=ramload.
- Simultaneous iREN and dREN from IDLE -> DGNT first and iwait held at 1. IGNT follows after the dcache completes and the next IDLE cycle.
- Dcache two-word burst writeback to 0x200 then 0x204, dWEN held -> no IDLE between the words. ramWEN=1 both times; ramstore tracks dstore.
- Dcache requests to different blocks back-to-back, iREN held, STARVE_LIMIT=4 -> 4 DGNT grants, then IGNT. starve_cnt is 0 after the icache grant.
- ramstate=ERROR during IGNT -> ramerr high for 1 cycle, iwait stays 1, FSM returns to IDLE.
- RST pulsed while DGNT is waiting on BUSY -> ramREN and ramWEN drop to 0 immediately. After release, state=IDLE and dwait=1.
